// File: rtl/rpn_stack_ctrl_if.sv
// rtl/rpn_stack_ctrl_if.sv - token, stack and result signals of the RPN stack controller
interface rpn_stack_ctrl_if #(
  parameter int W = 4
);
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_op;
  logic [W-1:0] tok_val;
  logic [W-1:0] stk_data;
  logic         stk_push;
  logic         stk_pop;
  logic [W-1:0] stk_q;
  logic         stk_full;
  logic         stk_empty;
  logic [W-1:0] res;
  logic         res_valid;
  logic         err;
  logic [1:0]   err_code;

  // Controller side: drives the stack and reports results
  modport master (
    input  tok_valid, tok_op, tok_val, stk_q, stk_full, stk_empty,
    output tok_ready, stk_data, stk_push, stk_pop, res, res_valid, err, err_code
  );

  // Environment side: token source, stack instance and result consumer
  modport slave (
    output tok_valid, tok_op, tok_val, stk_q, stk_full, stk_empty,
    input  tok_ready, stk_data, stk_push, stk_pop, res, res_valid, err, err_code
  );
endinterface

// File: rtl/rpn_stack_ctrl.sv
// rtl/rpn_stack_ctrl.sv - RPN evaluator driving an external push/pop LIFO
module rpn_stack_ctrl #(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rstN,
  rpn_stack_ctrl_if.master   bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH_LIT = 3'd1;
  localparam logic [2:0] S_POP_B    = 3'd2;
  localparam logic [2:0] S_POP_A    = 3'd3;
  localparam logic [2:0] S_CAP_A    = 3'd4;
  localparam logic [2:0] S_PUSH_RES = 3'd5;
  localparam logic [2:0] S_ERR      = 3'd6;

  localparam logic [1:0] E_UNDER = 2'b01;
  localparam logic [1:0] E_OVER  = 2'b10;
  localparam logic [1:0] E_OPC   = 2'b11;

  logic [2:0]    state;
  logic [DW-1:0] depth;
  logic [2:0]    opc;
  logic [W-1:0]  b_reg;

  // a = deeper operand, b = former top; arithmetic wraps mod 2^W
  function automatic logic [W-1:0] alu(input logic [2:0] op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Sequencer: every output is registered and set on the edge entering its state.
  // Operand a is consumed straight from stk_q on the CAP_A edge so the result is
  // already on stk_data/res during PUSH_RES.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= S_IDLE;
      depth         <= '0;
      opc           <= '0;
      b_reg         <= '0;
      bus.tok_ready <= 1'b0;
      bus.stk_data  <= '0;
      bus.stk_push  <= 1'b0;
      bus.stk_pop   <= 1'b0;
      bus.res       <= '0;
      bus.res_valid <= 1'b0;
      bus.err       <= 1'b0;
      bus.err_code  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          bus.tok_ready <= 1'b1;
          if (bus.tok_valid && bus.tok_ready) begin
            bus.tok_ready <= 1'b0;
            if (!bus.tok_op) begin
              if (depth == DEPTH_C || bus.stk_full) begin
                state        <= S_ERR;
                bus.err      <= 1'b1;
                bus.err_code <= E_OVER;
              end else begin
                state        <= S_PUSH_LIT;
                bus.stk_push <= 1'b1;
                bus.stk_data <= bus.tok_val;
                depth        <= depth + 1'b1;
              end
            end else if (bus.tok_val > W'(4)) begin
              state        <= S_ERR;
              bus.err      <= 1'b1;
              bus.err_code <= E_OPC;
            end else if (depth < DW'(2) || bus.stk_empty) begin
              state        <= S_ERR;
              bus.err      <= 1'b1;
              bus.err_code <= E_UNDER;
            end else begin
              state       <= S_POP_B;
              opc         <= bus.tok_val[2:0];
              bus.stk_pop <= 1'b1;
            end
          end
        end
        S_PUSH_LIT: begin
          bus.stk_push  <= 1'b0;
          bus.tok_ready <= 1'b1;
          state         <= S_IDLE;
        end
        S_POP_B: begin
          if (depth != '0) depth <= depth - 1'b1;
          state <= S_POP_A;
        end
        S_POP_A: begin
          b_reg       <= bus.stk_q;
          bus.stk_pop <= 1'b0;
          if (depth != '0) depth <= depth - 1'b1;
          state <= S_CAP_A;
        end
        S_CAP_A: begin
          bus.stk_push  <= 1'b1;
          bus.stk_data  <= alu(opc, bus.stk_q, b_reg);
          bus.res       <= alu(opc, bus.stk_q, b_reg);
          bus.res_valid <= 1'b1;
          if (depth != DEPTH_C) depth <= depth + 1'b1;
          state <= S_PUSH_RES;
        end
        S_PUSH_RES: begin
          bus.stk_push  <= 1'b0;
          bus.res_valid <= 1'b0;
          bus.tok_ready <= 1'b1;
          state         <= S_IDLE;
        end
        S_ERR: begin
          bus.tok_ready <= 1'b0;
          bus.stk_push  <= 1'b0;
          bus.stk_pop   <= 1'b0;
          bus.res_valid <= 1'b0;
          bus.err       <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// tb/tb_rpn_stack_ctrl.sv - directed self-checking bench for rpn_stack_ctrl
module tb_rpn_stack_ctrl;
  logic clk;
  logic rstN;
  int   n_cmp;
  int   n_bad;

  rpn_stack_ctrl_if #(.W(4)) bus ();

  rpn_stack_ctrl #(.W(4), .DEPTH(8)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8x4 LIFO: q updates on the edge that performs a pop
  logic [3:0] mem [8];
  int         top;
  logic [3:0] q;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      top <= 0;
      q   <= 4'h0;
    end else if (bus.stk_push && top < 8) begin
      mem[top] <= bus.stk_data;
      top      <= top + 1;
    end else if (bus.stk_pop && top > 0) begin
      q   <= mem[top-1];
      top <= top - 1;
    end
  end
  assign bus.stk_q     = q;
  assign bus.stk_full  = (top == 8);
  assign bus.stk_empty = (top == 0);

  // Per-cycle activity counters sampled mid-cycle
  int pushes, pops, rvs, both;
  initial begin pushes = 0; pops = 0; rvs = 0; both = 0; end
  always @(negedge clk) begin
    if (bus.stk_push) pushes++;
    if (bus.stk_pop) pops++;
    if (bus.res_valid) rvs++;
    if (bus.stk_push && bus.stk_pop) both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.tok_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.tok_ready), 32'd1);
  endtask

  task automatic send_tok(input logic op, input logic [3:0] v);
    wait_ready("tok_ready_wait");
    bus.tok_op    = op;
    bus.tok_val   = v;
    bus.tok_valid = 1'b1;
    @(posedge clk);
    #1 bus.tok_valid = 1'b0;
  endtask

  int p0, q0, r0;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstN = 1'b1;
    bus.tok_valid = 1'b0;
    bus.tok_op = 1'b0;
    bus.tok_val = 4'h0;

    // Reset state
    #2 rstN = 1'b0;
    #1;
    check("rst_tok_ready", 32'(bus.tok_ready), 32'd0);
    check("rst_push", 32'(bus.stk_push), 32'd0);
    check("rst_pop", 32'(bus.stk_pop), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // 1: 3 5 + = 8
    p0 = pushes; q0 = pops; r0 = rvs;
    send_tok(1'b0, 4'd3);
    send_tok(1'b0, 4'd5);
    send_tok(1'b1, 4'd0);
    wait_ready("t1_done");
    check("t1_res", 32'(bus.res), 32'h8);
    check("t1_res_valid_cycles", 32'(rvs - r0), 32'd1);
    check("t1_pushes", 32'(pushes - p0), 32'd3);
    check("t1_pops", 32'(pops - q0), 32'd2);
    check("t1_depth", 32'(top), 32'd1);
    check("t1_top_val", 32'(mem[0]), 32'h8);

    // 2: 2 7 - = B, then B 4 ^ = F
    do_reset();
    send_tok(1'b0, 4'd2);
    send_tok(1'b0, 4'd7);
    send_tok(1'b1, 4'd1);
    wait_ready("t2a_done");
    check("t2_sub_res", 32'(bus.res), 32'hB);
    send_tok(1'b0, 4'd4);
    send_tok(1'b1, 4'd4);
    wait_ready("t2b_done");
    check("t2_xor_res", 32'(bus.res), 32'hF);
    check("t2_depth", 32'(top), 32'd1);
    check("t2_err", 32'(bus.err), 32'd0);

    // 3: overflow on the 9th literal
    do_reset();
    p0 = pushes;
    for (int i = 0; i < 8; i++) send_tok(1'b0, 4'(i + 1));
    wait_ready("t3_fill_done");
    check("t3_depth_full", 32'(top), 32'd8);
    check("t3_mem7", 32'(mem[7]), 32'd8);
    send_tok(1'b0, 4'hA);
    repeat (5) @(negedge clk);
    check("t3_err", 32'(bus.err), 32'd1);
    check("t3_err_code", 32'(bus.err_code), 32'd2);
    check("t3_pushes", 32'(pushes - p0), 32'd8);
    check("t3_tok_ready", 32'(bus.tok_ready), 32'd0);

    // 4: underflow, no pop
    do_reset();
    q0 = pops;
    send_tok(1'b0, 4'd1);
    send_tok(1'b1, 4'd2);
    repeat (5) @(negedge clk);
    check("t4_err_code", 32'(bus.err_code), 32'd1);
    check("t4_pops", 32'(pops - q0), 32'd0);
    check("t4_depth", 32'(top), 32'd1);
    check("t4_stack_val", 32'(mem[0]), 32'd1);

    // 5: illegal opcode, then async reset
    do_reset();
    q0 = pops;
    send_tok(1'b0, 4'd1);
    send_tok(1'b0, 4'd1);
    send_tok(1'b1, 4'd9);
    repeat (4) @(negedge clk);
    check("t5_err_code", 32'(bus.err_code), 32'd3);
    check("t5_pops", 32'(pops - q0), 32'd0);
    #2 rstN = 1'b0;
    #1;
    check("t5_async_err", 32'(bus.err), 32'd0);
    check("t5_async_code", 32'(bus.err_code), 32'd0);
    check("t5_async_ready", 32'(bus.tok_ready), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    check("t5_ready_before_edge", 32'(bus.tok_ready), 32'd0);
    @(posedge clk);
    #1;
    check("t5_ready_after_edge", 32'(bus.tok_ready), 32'd1);

    // 6: reset pulse during CAP_A aborts the operation
    do_reset();
    send_tok(1'b0, 4'd9);
    send_tok(1'b0, 4'd9);
    send_tok(1'b1, 4'd0);
    p0 = pushes; r0 = rvs;
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b0;
    #2 rstN = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_push", 32'(pushes - p0), 32'd0);
    check("t6_no_res_valid", 32'(rvs - r0), 32'd0);
    check("t6_res", 32'(bus.res), 32'd0);
    check("t6_idle_ready", 32'(bus.tok_ready), 32'd1);
    check("t6_err", 32'(bus.err), 32'd0);

    check("push_pop_exclusive", 32'(both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
